// File: rtl/approx_add_pkg.sv
// Shared cell functions, mode encoding and saturating arithmetic for the
// approximate ripple-carry adder family.
package approx_add_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  localparam int unsigned SAT_W = 64;

  function automatic logic approx_cell_s(input logic x, input logic y, input logic z);
    return ~x & (y | z);
  endfunction

  // The approximate cell forwards the a-bit as carry; b and carry-in are ignored.
  function automatic logic approx_cell_c(input logic x);
    return x;
  endfunction

  // Returns {cout, sum}.
  function automatic logic [1:0] exact_cell(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  // Adds inc to acc, clamping at the all-ones value of a w-bit counter (w <= SAT_W).
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                               input logic [SAT_W-1:0] inc,
                                               input int unsigned      w);
    logic [SAT_W:0]   sum;
    logic [SAT_W-1:0] lim;
    lim = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
    sum = {1'b0, acc} + {1'b0, inc};
    return (sum > {1'b0, lim}) ? lim : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/approx_rc_segment.sv
// One combinational carry segment computing the selectable approximate chain
// and the always-exact shadow chain side by side.
module approx_rc_segment
  import approx_add_pkg::*;
#(
  parameter int unsigned SEG_W       = 8,
  parameter int unsigned BASE_BIT    = 0,
  parameter int unsigned APPROX_BITS = 2
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             mode,
  input  logic             c_ap,
  input  logic             c_ex,
  output logic [SEG_W-1:0] sum_ap_c,
  output logic [SEG_W-1:0] sum_ex_c,
  output logic             cout_ap_c,
  output logic             cout_ex_c
);

  logic cap;
  logic cex;

  always_comb begin
    cap      = c_ap;
    cex      = c_ex;
    sum_ap_c = '0;
    sum_ex_c = '0;
    for (int i = 0; i < int'(SEG_W); i++) begin
      // Absolute bit position decides whether the approximate cell applies.
      if ((mode == MODE_APPROX) && (int'(BASE_BIT) + i < int'(APPROX_BITS))) begin
        sum_ap_c[i] = approx_cell_s(a[i], b[i], cap);
        cap         = approx_cell_c(a[i]);
      end else begin
        {cap, sum_ap_c[i]} = exact_cell(a[i], b[i], cap);
      end
      {cex, sum_ex_c[i]} = exact_cell(a[i], b[i], cex);
    end
    cout_ap_c = cap;
    cout_ex_c = cex;
  end

endmodule

// File: rtl/approx_rc_adder_pipe.sv
// Pipelined approximate ripple-carry adder with runtime exact/approx mode and
// an on-line error statistics monitor.
module approx_rc_adder_pipe
  import approx_add_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned APPROX_BITS = 2,
  parameter int unsigned STAGES      = 2,
  parameter int unsigned ACC_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [WIDTH:0]   out_err,
  input  logic             stat_clear,
  output logic [ACC_W-1:0] stat_samples,
  output logic [ACC_W-1:0] stat_mismatch,
  output logic [ACC_W-1:0] stat_err_sum,
  output logic [WIDTH:0]   stat_err_max
);

  localparam int unsigned SEG_W = WIDTH / STAGES;
  localparam int unsigned SUM_W = WIDTH + 1;

  logic             adv;
  logic             st_valid [STAGES];
  logic             st_mode  [STAGES];
  logic [WIDTH-1:0] st_a     [STAGES];
  logic [WIDTH-1:0] st_b     [STAGES];
  logic [WIDTH-1:0] st_sap   [STAGES];
  logic [WIDTH-1:0] st_sex   [STAGES];
  logic             st_cap   [STAGES];
  logic             st_cex   [STAGES];

  logic [SEG_W-1:0] seg_sap  [STAGES];
  logic [SEG_W-1:0] seg_sex  [STAGES];
  logic             seg_cap  [STAGES];
  logic             seg_cex  [STAGES];
  logic [WIDTH-1:0] nxt_sap  [STAGES];
  logic [WIDTH-1:0] nxt_sex  [STAGES];

  logic [SUM_W-1:0] fin_ap;
  logic [SUM_W-1:0] fin_ex;
  logic [SUM_W-1:0] fin_err;

  // Single global enable: everything moves unless a valid result is blocked.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_seg
    approx_rc_segment #(
      .SEG_W      (SEG_W),
      .BASE_BIT   (k * SEG_W),
      .APPROX_BITS(APPROX_BITS)
    ) u_seg (
      .a        (st_a[k][k*SEG_W +: SEG_W]),
      .b        (st_b[k][k*SEG_W +: SEG_W]),
      .mode     (st_mode[k]),
      .c_ap     (st_cap[k]),
      .c_ex     (st_cex[k]),
      .sum_ap_c (seg_sap[k]),
      .sum_ex_c (seg_sex[k]),
      .cout_ap_c(seg_cap[k]),
      .cout_ex_c(seg_cex[k])
    );
  end

  // Merge each segment's fresh sum bits into the beat's partial sums.
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      nxt_sap[k]                    = st_sap[k];
      nxt_sex[k]                    = st_sex[k];
      nxt_sap[k][k*SEG_W +: SEG_W]  = seg_sap[k];
      nxt_sex[k][k*SEG_W +: SEG_W]  = seg_sex[k];
    end
  end

  assign fin_ap  = {seg_cap[STAGES-1], nxt_sap[STAGES-1]};
  assign fin_ex  = {seg_cex[STAGES-1], nxt_sex[STAGES-1]};
  assign fin_err = (fin_ap >= fin_ex) ? (fin_ap - fin_ex) : (fin_ex - fin_ap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        st_valid[k] <= 1'b0;
        st_mode[k]  <= MODE_EXACT;
        st_a[k]     <= '0;
        st_b[k]     <= '0;
        st_sap[k]   <= '0;
        st_sex[k]   <= '0;
        st_cap[k]   <= 1'b0;
        st_cex[k]   <= 1'b0;
      end
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_err   <= '0;
    end else if (adv) begin
      st_valid[0] <= in_valid;
      st_mode[0]  <= in_approx;
      st_a[0]     <= in_a;
      st_b[0]     <= in_b;
      st_sap[0]   <= '0;
      st_sex[0]   <= '0;
      st_cap[0]   <= 1'b0;
      st_cex[0]   <= 1'b0;
      for (int k = 1; k < int'(STAGES); k++) begin
        st_valid[k] <= st_valid[k-1];
        st_mode[k]  <= st_mode[k-1];
        st_a[k]     <= st_a[k-1];
        st_b[k]     <= st_b[k-1];
        st_sap[k]   <= nxt_sap[k-1];
        st_sex[k]   <= nxt_sex[k-1];
        st_cap[k]   <= seg_cap[k-1];
        st_cex[k]   <= seg_cex[k-1];
      end
      out_valid <= st_valid[STAGES-1];
      out_sum   <= fin_ap;
      out_err   <= fin_err;
    end
  end

  // Statistics; clear wins over a coincident handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_samples  <= '0;
      stat_mismatch <= '0;
      stat_err_sum  <= '0;
      stat_err_max  <= '0;
    end else if (stat_clear) begin
      stat_samples  <= '0;
      stat_mismatch <= '0;
      stat_err_sum  <= '0;
      stat_err_max  <= '0;
    end else if (out_valid && out_ready) begin
      stat_samples <= ACC_W'(sat_add(SAT_W'(stat_samples), SAT_W'(1), ACC_W));
      if (out_err != '0) begin
        stat_mismatch <= ACC_W'(sat_add(SAT_W'(stat_mismatch), SAT_W'(1), ACC_W));
      end
      stat_err_sum <= ACC_W'(sat_add(SAT_W'(stat_err_sum), SAT_W'(out_err), ACC_W));
      if (out_err > stat_err_max) begin
        stat_err_max <= out_err;
      end
    end
  end

endmodule

// File: tb/tb_approx_rc_adder_pipe.sv
// Directed-vector bench for approx_rc_adder_pipe (16-bit, 2 approx bits, 2 stages).
module tb_approx_rc_adder_pipe;

  localparam int unsigned WIDTH       = 16;
  localparam int unsigned APPROX_BITS = 2;
  localparam int unsigned STAGES      = 2;
  localparam int unsigned ACC_W       = 32;
  localparam int          N_RAND      = 10000;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_approx;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic [WIDTH:0]   out_err;
  logic             stat_clear;
  logic [ACC_W-1:0] stat_samples;
  logic [ACC_W-1:0] stat_mismatch;
  logic [ACC_W-1:0] stat_err_sum;
  logic [WIDTH:0]   stat_err_max;

  int n_cmp;
  int n_bad;

  logic [WIDTH:0] exp_q[$];

  approx_rc_adder_pipe #(
    .WIDTH(WIDTH), .APPROX_BITS(APPROX_BITS), .STAGES(STAGES), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_err(out_err),
    .stat_clear(stat_clear),
    .stat_samples(stat_samples), .stat_mismatch(stat_mismatch),
    .stat_err_sum(stat_err_sum), .stat_err_max(stat_err_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated beat with out_ready high; checks latency and result.
  task automatic run_beat(input logic [15:0] a, input logic [15:0] b, input logic mode,
                          input logic [16:0] esum, input logic [16:0] eerr);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_approx = mode; out_ready = 1'b1;
    #1 check("beat_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(STAGES));
    check("sum", 64'(out_sum), 64'(esum));
    check("err", 64'(out_err), 64'(eerr));
    @(negedge clk);
  endtask

  task automatic check_stats(input string tag, input int s, input int m, input int es, input int em);
    check({tag, "_samples"},  64'(stat_samples),  64'(s));
    check({tag, "_mismatch"}, 64'(stat_mismatch), 64'(m));
    check({tag, "_err_sum"},  64'(stat_err_sum),  64'(es));
    check({tag, "_err_max"},  64'(stat_err_max),  64'(em));
  endtask

  initial begin
    int sent;
    int rcvd;
    int cyc;
    logic held_v;
    logic [16:0] held_sum;
    logic [16:0] exp_sum;

    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = 1'b0;
    out_ready = 1'b0; stat_clear = 1'b0;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check_stats("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Approximate-mode vectors
    run_beat(16'h0003, 16'h0000, 1'b1, 17'h00004, 17'd1);
    check_stats("v1", 1, 1, 1, 1);
    @(negedge clk); stat_clear = 1'b1;
    @(negedge clk); stat_clear = 1'b0;
    check_stats("clr1", 0, 0, 0, 0);
    run_beat(16'h0002, 16'h0001, 1'b1, 17'h00005, 17'd2);
    run_beat(16'h0001, 16'h0001, 1'b1, 17'h00002, 17'd0);
    check_stats("v23", 2, 1, 2, 2);
    run_beat(16'h0001, 16'h0002, 1'b1, 17'h00002, 17'd1);
    run_beat(16'h0003, 16'h0003, 1'b1, 17'h00004, 17'd2);
    run_beat(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 17'd0);
    run_beat(16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, 17'd0);
    check_stats("v6", 6, 3, 5, 2);

    // Back-to-back stream with out_ready toggling every cycle
    sent = 0; rcvd = 0; cyc = 0; held_v = 1'b0; held_sum = '0;
    exp_q.delete();
    while (rcvd < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (held_v) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_sum", 64'(out_sum), 64'(held_sum));
      end
      out_ready = ((cyc % 2) == 1);
      in_valid  = (sent < 8);
      in_a      = 16'(sent * 16'h1357 + 16'h0F0F);
      in_b      = 16'(16'hA5A5 ^ (sent * 16'h0101));
      in_approx = 1'b0;
      #1;
      check("stream_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 64'd1, 64'd0);
        end else begin
          exp_sum = exp_q.pop_front();
          check("stream_sum", 64'(out_sum), 64'(exp_sum));
        end
        rcvd++;
      end
      held_v   = out_valid && !out_ready;
      held_sum = out_sum;
    end
    check("stream_count", 64'(rcvd), 64'd8);
    check("stream_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // Stat clear coinciding with a handshake
    out_ready = 1'b0; in_valid = 1'b1; in_a = 16'd7; in_b = 16'd9; in_approx = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("clr_pre_valid", 64'(out_valid), 64'd1);
    check("clr_pre_sum", 64'(out_sum), 64'd16);
    out_ready = 1'b1; stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    check("clr_hs_valid", 64'(out_valid), 64'd0);
    check_stats("clr2", 0, 0, 0, 0);
    run_beat(16'h0003, 16'h0000, 1'b1, 17'h00004, 17'd1);
    check_stats("post_clr", 1, 1, 1, 1);

    // Reset with beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 16'(i + 1); in_b = 16'h0100; in_approx = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(out_sum), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_samples", 64'(stat_samples), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) cyc++;
    end
    check("stale_after_rst", 64'(cyc), 64'd0);
    run_beat(16'h0005, 16'h0006, 1'b0, 17'h0000B, 17'd0);

    // Random exact-mode stream against a+b
    sent = 0; rcvd = 0; cyc = 0;
    exp_q.delete();
    out_ready = 1'b1;
    while (rcvd < N_RAND && cyc < N_RAND + 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("rand_extra", 64'd1, 64'd0);
        end else begin
          exp_sum = exp_q.pop_front();
          check("rand_sum", 64'(out_sum), 64'(exp_sum));
        end
        rcvd++;
      end
      in_valid  = (sent < N_RAND);
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_approx = 1'b0;
      if (in_valid) begin
        exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
        sent++;
      end
    end
    in_valid = 1'b0;
    check("rand_count", 64'(rcvd), 64'(N_RAND));
    @(negedge clk);
    check_stats("rand", N_RAND + 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
